// File: rtl/e_cpu_io_bridge_if.sv
// CPU request/response handshake plus E_CPU_IO tile lanes for one custom-instruction bridge.
interface e_cpu_io_bridge_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 4;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_opa;
    logic [DATA_W-1:0] req_opb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [LANE_W-1:0] OPA_I;
    logic [LANE_W-1:0] OPB_I;
    logic [LANE_W-1:0] RES0_O;
    logic [LANE_W-1:0] RES1_O;
    logic [LANE_W-1:0] RES2_O;

    // CPU and fabric tile side
    modport master (
        output req_valid, req_opa, req_opb, rsp_ready, RES0_O, RES1_O, RES2_O,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout, OPA_I, OPB_I
    );

    // Bridge side
    modport slave (
        input  req_valid, req_opa, req_opb, rsp_ready, RES0_O, RES1_O, RES2_O,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout, OPA_I, OPB_I
    );
endinterface

// File: rtl/e_cpu_io_bridge.sv
// Serialises a CPU operand pair onto the E_CPU_IO OPA/OPB lanes in 7-bit beats and
// gathers three 11-bit result beats from RES0/1/2 into a 32-bit result with error/timeout.
module e_cpu_io_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                UserCLK,
    input logic                resetn,
    e_cpu_io_bridge_if.slave   bus
);
    localparam int unsigned FRAME_W    = 70;
    localparam int unsigned BEAT_W     = 7;
    localparam int unsigned N_BEATS    = 10;
    localparam int unsigned BCNT_W     = 4;
    localparam int unsigned RES_W      = 33;
    localparam int unsigned RBEAT_W    = 11;
    localparam int unsigned RCNT_W     = 2;
    localparam int unsigned N_RBEATS   = 3;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [BCNT_W-1:0]   beat_q, beat_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [3:0]          opa_q, opa_d;
    logic [3:0]          opb_q, opb_d;

    logic                accept;
    logic                res_beat;
    logic                last_send;
    logic                last_res;
    logic                timed_out;
    logic [RBEAT_W-1:0]  res_payload;
    logic [RES_W-1:0]    res_shift;
    logic [FRAME_W-1:0]  new_frame;

    assign accept      = (state_q == IDLE) && bus.req_valid;
    assign res_beat    = (state_q == WAIT) && bus.RES2_O[3];
    assign res_payload = {bus.RES2_O[2:0], bus.RES1_O, bus.RES0_O};
    assign res_shift   = {res_payload, res_q[RES_W-1:RBEAT_W]};
    assign last_send   = (beat_q == BCNT_W'(N_BEATS - 1));
    assign last_res    = res_beat && (rcnt_q == RCNT_W'(N_RBEATS - 1));
    // A beat on the deadline cycle wins over the timeout
    assign timed_out   = (state_q == WAIT) && !res_beat && (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign new_frame   = {6'b0, bus.req_opb, bus.req_opa};

    // State and registered outputs
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            beat_q        <= '0;
            res_q         <= '0;
            rcnt_q        <= '0;
            tcnt_q        <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            beat_q        <= beat_d;
            res_q         <= res_d;
            rcnt_q        <= rcnt_d;
            tcnt_q        <= tcnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (last_send) state_d = WAIT;
            WAIT:    if (last_res || timed_out) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; lanes fall back to zero outside SEND
    always_comb begin
        frame_d       = frame_q;
        beat_d        = beat_q;
        res_d         = res_q;
        rcnt_d        = rcnt_q;
        tcnt_d        = tcnt_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        opa_d         = 4'h0;
        opb_d         = 4'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d       = new_frame >> BEAT_W;
                    beat_d        = '0;
                    req_ready_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    opa_d         = new_frame[3:0];
                    opb_d         = {1'b1, new_frame[6:4]};
                end
            end
            SEND: begin
                if (last_send) begin
                    tcnt_d = '0;
                    rcnt_d = '0;
                end else begin
                    frame_d = frame_q >> BEAT_W;
                    beat_d  = beat_q + BCNT_W'(1);
                    opa_d   = frame_q[3:0];
                    opb_d   = {1'b1, frame_q[6:4]};
                end
            end
            WAIT: begin
                if (res_beat) begin
                    res_d  = res_shift;
                    rcnt_d = rcnt_q + RCNT_W'(1);
                    tcnt_d = '0;
                    if (last_res) begin
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = res_shift[31:0];
                        rsp_err_d     = res_shift[32];
                        rsp_timeout_d = 1'b0;
                    end
                end else if (timed_out) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.OPA_I       = opa_q;
    assign bus.OPB_I       = opb_q;

endmodule

// File: tb/tb_e_cpu_io_bridge.sv
// Directed bench for e_cpu_io_bridge: beat serialisation, result assembly, error,
// timeout boundary, stray beats, backpressure and mid-operation reset.
module tb_e_cpu_io_bridge;
    logic       clk = 1'b0;
    logic       resetn;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] beats [10];

    e_cpu_io_bridge_if bus();

    e_cpu_io_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .UserCLK (clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"},   32'(bus.req_ready),   32'd1);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
        chk({tag, "_rsp_data"},    bus.rsp_data,         32'd0);
        chk({tag, "_rsp_err"},     32'(bus.rsp_err),     32'd0);
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
        chk({tag, "_opa"},         32'(bus.OPA_I),       32'd0);
        chk({tag, "_opb"},         32'(bus.OPB_I),       32'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.req_opa   = a;
        bus.req_opb   = b;
        bus.req_valid = 1'b1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    endtask

    // Checks all ten beats; optionally drives stray result beats during beats 3 and 6
    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input bit stray);
        logic [69:0] f;
        f = {6'b0, b, a};
        for (int k = 0; k < 10; k++) begin
            beats[k] = {bus.OPB_I, bus.OPA_I};
            chk($sformatf("beat%0d_opa", k), 32'(bus.OPA_I), 32'(f[3:0]));
            chk($sformatf("beat%0d_opb", k), 32'(bus.OPB_I), 32'({1'b1, f[6:4]}));
            if (stray && (k == 3 || k == 6)) begin
                bus.RES2_O = 4'hF;
                bus.RES1_O = 4'hF;
                bus.RES0_O = 4'hF;
            end else begin
                bus.RES2_O = 4'h0;
                bus.RES1_O = 4'h0;
                bus.RES0_O = 4'h0;
            end
            f = f >> 7;
            tick();
        end
        bus.RES2_O = 4'h0;
        bus.RES1_O = 4'h0;
        bus.RES0_O = 4'h0;
        chk("opa_after_send", 32'(bus.OPA_I), 32'd0);
        chk("opb_after_send", 32'(bus.OPB_I), 32'd0);
    endtask

    task automatic res_beat(input logic [10:0] p);
        bus.RES2_O = {1'b1, p[10:8]};
        bus.RES1_O = p[7:4];
        bus.RES0_O = p[3:0];
        tick();
        bus.RES2_O = 4'h0;
        bus.RES1_O = 4'h0;
        bus.RES0_O = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic finish_rsp(input string tag, input logic [31:0] data, input logic err, input logic to);
        chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd1);
        chk({tag, "_rsp_data"},    bus.rsp_data,         data);
        chk({tag, "_rsp_err"},     32'(bus.rsp_err),     32'(err));
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(to));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_valid_drop"},  32'(bus.rsp_valid),   32'd0);
        chk({tag, "_ready_back"},  32'(bus.req_ready),   32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        bus.rsp_ready = 1'b0;
        bus.RES0_O    = 4'h0;
        bus.RES1_O    = 4'h0;
        bus.RES2_O    = 4'h0;
        resetn        = 1'b0;
        tick();
        tick();
        check_reset("por");
        resetn = 1'b1;

        // Single operation with hand-checked beats and result
        start_op(32'h12345678, 32'h9ABCDEF0);
        send_frame(32'h12345678, 32'h9ABCDEF0, 1'b0);
        chk("t1_beat0", 32'(beats[0]), 32'h000000F8);
        chk("t1_beat1", 32'(beats[1]), 32'h000000AC);
        chk("t1_beat9", 32'(beats[9]), 32'h00000081);
        res_beat(11'h00D);
        res_beat(11'h7DE);
        chk("t1_not_yet", 32'(bus.rsp_valid), 32'd0);
        res_beat(11'h32B);
        finish_rsp("t1", 32'hCAFEF00D, 1'b0, 1'b0);

        // Error flag with gaps between result beats
        start_op(32'h00000001, 32'h00000002);
        send_frame(32'h00000001, 32'h00000002, 1'b0);
        res_beat(11'h001);
        idle(5);
        res_beat(11'h000);
        idle(5);
        chk("t2_not_yet", 32'(bus.rsp_valid), 32'd0);
        res_beat(11'h400);
        finish_rsp("t2", 32'h00000001, 1'b1, 1'b0);

        // Beat landing on the deadline cycle is accepted
        start_op(32'hA5A5A5A5, 32'h5A5A5A5A);
        send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
        res_beat(11'h001);
        idle(15);
        res_beat(11'h002);
        chk("t3_no_timeout", 32'(bus.rsp_valid), 32'd0);
        idle(15);
        res_beat(11'h004);
        finish_rsp("t3", 32'h01001001, 1'b0, 1'b0);

        // Timeout after one beat, then a clean operation
        start_op(32'h0BADF00D, 32'hDEADBEEF);
        send_frame(32'h0BADF00D, 32'hDEADBEEF, 1'b0);
        res_beat(11'h123);
        idle(15);
        chk("t4_valid_at_15", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t4_valid_at_16", 32'(bus.rsp_valid), 32'd1);
        finish_rsp("t4", 32'h00000000, 1'b1, 1'b1);
        start_op(32'h00000010, 32'h00000020);
        chk("t4b_timeout_clear", 32'(bus.rsp_timeout), 32'd0);
        send_frame(32'h00000010, 32'h00000020, 1'b0);
        res_beat(11'h0AB);
        res_beat(11'h1CD);
        res_beat(11'h0EF);
        finish_rsp("t4b", 32'h3BCE68AB, 1'b0, 1'b0);

        // Stray beats in IDLE/SEND/RESP ignored, held response under backpressure
        res_beat(11'h7FF);
        idle(2);
        start_op(32'h13579BDF, 32'h2468ACE0);
        send_frame(32'h13579BDF, 32'h2468ACE0, 1'b1);
        res_beat(11'h111);
        res_beat(11'h222);
        res_beat(11'h333);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t5_hold_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("t5_hold_data%0d", i),  bus.rsp_data,       32'hCCD11111);
            chk($sformatf("t5_hold_ready%0d", i), 32'(bus.req_ready), 32'd0);
            bus.RES2_O = (i == 10) ? 4'hF : 4'h0;
            tick();
        end
        bus.RES2_O = 4'h0;
        finish_rsp("t5", 32'hCCD11111, 1'b0, 1'b0);

        // Reset at SEND beat 4
        start_op(32'h12345678, 32'h9ABCDEF0);
        idle(4);
        chk("t6_beat4_valid", 32'(bus.OPB_I[3]), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_reset("t6_rst_send");

        // Reset in WAIT after one result beat
        start_op(32'h11111111, 32'h22222222);
        send_frame(32'h11111111, 32'h22222222, 1'b0);
        res_beat(11'h555);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_reset("t6_rst_wait");

        // Operation after reset completes normally
        start_op(32'hFFFFFFFF, 32'h00000000);
        send_frame(32'hFFFFFFFF, 32'h00000000, 1'b0);
        chk("t7_beat0", 32'(beats[0]), 32'h000000FF);
        chk("t7_beat4", 32'(beats[4]), 32'h0000008F);
        res_beat(11'h7FF);
        res_beat(11'h7FF);
        res_beat(11'h3FF);
        finish_rsp("t7", 32'hFFFFFFFF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
